// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Brief    : Data-memory request/acknowledge bus between mem_stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory-access stage; issues loads/stores over req/ack,
//            stalls upstream while busy, registers the writeback payload.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [DATA_W-1:0]  alu_result,
    input  wire logic [DATA_W-1:0]  rdata2,
    input  wire logic               mem_wen,
    input  wire logic               mem_ren,
    input  wire logic               mem_to_reg,
    input  wire logic               reg_wen,
    input  wire logic [RADDR_W-1:0] reg_waddr,
    output logic                    stall,
    mem_stage_if.master             dmem,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    reg_wen_out,
    output logic [RADDR_W-1:0]      reg_waddr_out
);

    typedef enum logic [0:0] {
        c_idle = 1'b0,
        c_busy = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_access;

    logic                 r_req;
    logic                 r_we;
    logic [DATA_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_wb_data;
    logic                 r_reg_wen_out;
    logic [RADDR_W-1:0]   r_reg_waddr_out;

    logic                 r_cap_m2r;
    logic                 r_cap_wen;
    logic [RADDR_W-1:0]   r_cap_waddr;
    logic [DATA_W-1:0]    r_cap_alu;

    assign w_access = mem_wen | mem_ren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_access) w_state_nxt = c_busy;
            c_busy:  if (dmem.ack) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Writes take priority when both enables are set, so dmem_we follows mem_wen alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wb_data       <= '0;
            r_reg_wen_out   <= 1'b0;
            r_reg_waddr_out <= '0;
            r_cap_m2r       <= 1'b0;
            r_cap_wen       <= 1'b0;
            r_cap_waddr     <= '0;
            r_cap_alu       <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_access) begin
                        r_req         <= 1'b1;
                        r_we          <= mem_wen;
                        r_addr        <= alu_result;
                        r_wdata       <= rdata2;
                        r_cap_m2r     <= mem_to_reg;
                        r_cap_wen     <= reg_wen;
                        r_cap_waddr   <= reg_waddr;
                        r_cap_alu     <= alu_result;
                        r_reg_wen_out <= 1'b0;
                    end else begin
                        r_wb_data       <= alu_result;
                        r_reg_wen_out   <= reg_wen;
                        r_reg_waddr_out <= reg_waddr;
                    end
                end
                c_busy: begin
                    if (dmem.ack) begin
                        r_req           <= 1'b0;
                        r_we            <= 1'b0;
                        r_wb_data       <= (r_cap_m2r && !r_we) ? dmem.rdata : r_cap_alu;
                        r_reg_wen_out   <= r_cap_wen;
                        r_reg_waddr_out <= r_cap_waddr;
                    end
                end
                default: r_req <= 1'b0;
            endcase
        end
    end

    assign stall         = (r_state == c_busy);
    assign dmem.req      = r_req;
    assign dmem.we       = r_we;
    assign dmem.addr     = r_addr;
    assign dmem.wdata    = r_wdata;
    assign wb_data       = r_wb_data;
    assign reg_wen_out   = r_reg_wen_out;
    assign reg_waddr_out = r_reg_waddr_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [15:0] alu_result;
    logic [15:0] rdata2;
    logic        mem_wen;
    logic        mem_ren;
    logic        mem_to_reg;
    logic        reg_wen;
    logic [3:0]  reg_waddr;
    logic        stall;
    logic [15:0] wb_data;
    logic        reg_wen_out;
    logic [3:0]  reg_waddr_out;

    int n_vec;
    int n_err;

    mem_stage_if #(.DATA_W(16)) dmem ();

    mem_stage #(.DATA_W(16), .RADDR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_result    (alu_result),
        .rdata2        (rdata2),
        .mem_wen       (mem_wen),
        .mem_ren       (mem_ren),
        .mem_to_reg    (mem_to_reg),
        .reg_wen       (reg_wen),
        .reg_waddr     (reg_waddr),
        .stall         (stall),
        .dmem          (dmem),
        .wb_data       (wb_data),
        .reg_wen_out   (reg_wen_out),
        .reg_waddr_out (reg_waddr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        alu_result = 16'h0000; rdata2 = 16'h0000;
        mem_wen = 1'b0; mem_ren = 1'b0; mem_to_reg = 1'b0;
        reg_wen = 1'b0; reg_waddr = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        dmem.ack = 1'b0; dmem.rdata = 16'h0000;
        step(); step();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %h want 0", stall); end
        n_vec++; if (dmem.req !== 1'b0 || dmem.we !== 1'b0) begin n_err++; $display("FAIL rst_req_we: got %b%b want 00", dmem.req, dmem.we); end
        n_vec++; if (dmem.addr !== 16'h0 || dmem.wdata !== 16'h0) begin n_err++; $display("FAIL rst_addr_wdata: got %h/%h want 0000/0000", dmem.addr, dmem.wdata); end
        n_vec++; if (wb_data !== 16'h0 || reg_wen_out !== 1'b0 || reg_waddr_out !== 4'h0) begin n_err++; $display("FAIL rst_wb: got %h/%b/%h want 0000/0/0", wb_data, reg_wen_out, reg_waddr_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_stream();
        alu_result = 16'h1234; reg_wen = 1'b1; reg_waddr = 4'd3;
        step();
        n_vec++; if (wb_data !== 16'h1234 || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd3) begin n_err++; $display("FAIL alu1: got %h/%b/%h want 1234/1/3", wb_data, reg_wen_out, reg_waddr_out); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu1_stall: got %b want 0", stall); end
        alu_result = 16'h5678; reg_waddr = 4'd4;
        step();
        n_vec++; if (wb_data !== 16'h5678 || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd4) begin n_err++; $display("FAIL alu2: got %h/%b/%h want 5678/1/4", wb_data, reg_wen_out, reg_waddr_out); end
        n_vec++; if (stall !== 1'b0 || dmem.req !== 1'b0) begin n_err++; $display("FAIL alu2_stall_req: got %b/%b want 0/0", stall, dmem.req); end
        set_nop();
        step();
    endtask

    task automatic test_load_wait();
        mem_ren = 1'b1; mem_to_reg = 1'b1; alu_result = 16'h0040; reg_wen = 1'b1; reg_waddr = 4'd7;
        step();
        set_nop();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.addr !== 16'h0040) begin n_err++; $display("FAIL load_bus_c%0d: got req=%b we=%b addr=%h want 1/0/0040", i, dmem.req, dmem.we, dmem.addr); end
            n_vec++; if (stall !== 1'b1 || reg_wen_out !== 1'b0) begin n_err++; $display("FAIL load_stall_c%0d: got stall=%b wen=%b want 1/0", i, stall, reg_wen_out); end
            if (i == 2) begin dmem.ack = 1'b1; dmem.rdata = 16'hBEEF; end
            step();
        end
        dmem.ack = 1'b0; dmem.rdata = 16'h0000;
        n_vec++; if (wb_data !== 16'hBEEF || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd7) begin n_err++; $display("FAIL load_wb: got %h/%b/%h want beef/1/7", wb_data, reg_wen_out, reg_waddr_out); end
        n_vec++; if (stall !== 1'b0 || dmem.req !== 1'b0) begin n_err++; $display("FAIL load_done: got stall=%b req=%b want 0/0", stall, dmem.req); end
        step();
    endtask

    task automatic test_store();
        mem_wen = 1'b1; alu_result = 16'h0010; rdata2 = 16'hA5A5; reg_wen = 1'b0; reg_waddr = 4'd9;
        step();
        set_nop();
        n_vec++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.wdata !== 16'hA5A5 || dmem.addr !== 16'h0010) begin n_err++; $display("FAIL store_bus: got %b%b %h %h want 11 a5a5 0010", dmem.req, dmem.we, dmem.wdata, dmem.addr); end
        n_vec++; if (stall !== 1'b1 || reg_wen_out !== 1'b0) begin n_err++; $display("FAIL store_stall: got %b/%b want 1/0", stall, reg_wen_out); end
        dmem.ack = 1'b1; dmem.rdata = 16'h3333;
        step();
        dmem.ack = 1'b0;
        n_vec++; if (dmem.req !== 1'b0 || dmem.we !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL store_done: got req=%b we=%b stall=%b want 0/0/0", dmem.req, dmem.we, stall); end
        n_vec++; if (reg_wen_out !== 1'b0) begin n_err++; $display("FAIL store_wen: got %b want 0", reg_wen_out); end
    endtask

    task automatic test_held();
        mem_ren = 1'b1; mem_to_reg = 1'b1; alu_result = 16'h0080; reg_wen = 1'b1; reg_waddr = 4'd5;
        step();
        set_nop();
        alu_result = 16'h0003; reg_wen = 1'b1; reg_waddr = 4'd2;
        step();
        n_vec++; if (reg_wen_out !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL held_wait: got wen=%b stall=%b want 0/1", reg_wen_out, stall); end
        dmem.ack = 1'b1; dmem.rdata = 16'h1111;
        step();
        dmem.ack = 1'b0;
        n_vec++; if (wb_data !== 16'h1111 || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd5) begin n_err++; $display("FAIL held_load_wb: got %h/%b/%h want 1111/1/5", wb_data, reg_wen_out, reg_waddr_out); end
        step();
        n_vec++; if (wb_data !== 16'h0003 || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd2) begin n_err++; $display("FAIL held_alu_wb: got %h/%b/%h want 0003/1/2", wb_data, reg_wen_out, reg_waddr_out); end
        set_nop();
        step();
        n_vec++; if (reg_wen_out !== 1'b0) begin n_err++; $display("FAIL held_dup: got %b want 0", reg_wen_out); end
    endtask

    task automatic test_back_to_back();
        mem_wen = 1'b1; alu_result = 16'h0100; rdata2 = 16'h0001;
        step();
        alu_result = 16'h0102; rdata2 = 16'h0002;
        dmem.ack = 1'b1;
        step();
        dmem.ack = 1'b0;
        n_vec++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got req=%b stall=%b want 0/0", dmem.req, stall); end
        step();
        set_nop();
        n_vec++; if (dmem.req !== 1'b1 || dmem.addr !== 16'h0102 || dmem.wdata !== 16'h0002) begin n_err++; $display("FAIL b2b_second: got %b %h %h want 1 0102 0002", dmem.req, dmem.addr, dmem.wdata); end
        dmem.ack = 1'b1;
        step();
        dmem.ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_ren = 1'b1; mem_to_reg = 1'b1; alu_result = 16'h0200; reg_wen = 1'b1; reg_waddr = 4'd8;
        step();
        set_nop();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (dmem.req !== 1'b0 || stall !== 1'b0 || reg_wen_out !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got req=%b stall=%b wen=%b want 0/0/0", dmem.req, stall, reg_wen_out); end
        @(negedge clk);
        rst = 1'b0;
        alu_result = 16'h00AA; reg_wen = 1'b1; reg_waddr = 4'd9;
        step();
        n_vec++; if (wb_data !== 16'h00AA || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd9 || stall !== 1'b0) begin n_err++; $display("FAIL rstmid_alu: got %h/%b/%h stall=%b want 00aa/1/9/0", wb_data, reg_wen_out, reg_waddr_out, stall); end
        set_nop();
        step();
    endtask

    task automatic test_spurious_both();
        dmem.ack = 1'b1; dmem.rdata = 16'hFFFF;
        alu_result = 16'h0055; reg_wen = 1'b1; reg_waddr = 4'd1;
        step();
        n_vec++; if (stall !== 1'b0 || dmem.req !== 1'b0 || wb_data !== 16'h0055 || reg_wen_out !== 1'b1) begin n_err++; $display("FAIL spurious: got stall=%b req=%b wb=%h wen=%b want 0/0/0055/1", stall, dmem.req, wb_data, reg_wen_out); end
        dmem.ack = 1'b0;
        mem_wen = 1'b1; mem_ren = 1'b1; mem_to_reg = 1'b1;
        alu_result = 16'h0020; rdata2 = 16'h7777; reg_waddr = 4'd6;
        step();
        set_nop();
        n_vec++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.wdata !== 16'h7777 || dmem.addr !== 16'h0020) begin n_err++; $display("FAIL both_issue: got %b%b %h %h want 11 7777 0020", dmem.req, dmem.we, dmem.wdata, dmem.addr); end
        dmem.ack = 1'b1; dmem.rdata = 16'hDEAD;
        step();
        dmem.ack = 1'b0;
        n_vec++; if (wb_data !== 16'h0020 || reg_wen_out !== 1'b1 || reg_waddr_out !== 4'd6) begin n_err++; $display("FAIL both_wb: got %h/%b/%h want 0020/1/6", wb_data, reg_wen_out, reg_waddr_out); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_alu_stream();
        test_load_wait();
        test_store();
        test_held();
        test_back_to_back();
        test_reset_mid();
        test_spurious_both();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline, sitting directly downstream of the EXE/MEM pipeline register and upstream of writeback. It issues loads and stores to the data memory over a req/ack handshake and stalls the upstream stages while an access is outstanding. It also registers the writeback payload (data, enable, destination) for the register file.

## Interface
- DATA_W, 16, data/address width
- RADDR_W, 4, register-file address width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_result  in  DATA_W  EXE result; memory address when accessing memory
- rdata2  in  DATA_W  store data
- mem_wen  in  1  store request
- mem_ren  in  1  load request
- mem_to_reg  in  1  writeback selects load data instead of alu_result
- reg_wen  in  1  register-file write enable for this instruction
- reg_waddr  in  RADDR_W  destination register
- stall  out  1  holds EXE/MEM register and earlier stages; inputs are accepted only when stall=0
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1=write, 0=read, registered
- dmem_addr  out  DATA_W  registered address
- dmem_wdata  out  DATA_W  registered store data
- dmem_rdata  in  DATA_W  read data, valid in the ack cycle
- dmem_ack  in  1  completes the outstanding request
- wb_data  out  DATA_W  registered writeback data
- reg_wen_out  out  1  registered writeback enable
- reg_waddr_out  out  RADDR_W  registered destination

## Operation
- Two-state FSM: IDLE, BUSY. stall = (state == BUSY), combinational from state only.
- Accept: inputs are sampled on every rising edge where state is IDLE.
- IDLE, no access (mem_wen=0, mem_ren=0):
  - wb_data <= alu_result.
  - reg_wen_out <= reg_wen.
  - reg_waddr_out <= reg_waddr.
  - Stay in IDLE.
- IDLE, access (mem_wen or mem_ren):
  - Go to BUSY.
  - dmem_req <= 1, dmem_we <= mem_wen, dmem_addr <= alu_result, dmem_wdata <= rdata2.
  - Capture mem_to_reg, reg_wen, reg_waddr and alu_result internally.
  - Insert a bubble: reg_wen_out <= 0. wb_data and reg_waddr_out are don't-care.
- mem_wen and mem_ren both set: treated as a write, with writeback handled as for any access.
- BUSY, dmem_ack=0:
  - Hold all dmem_* outputs stable.
  - Keep reg_wen_out = 0.
- BUSY, dmem_ack=1:
  - dmem_req <= 0, dmem_we <= 0.
  - wb_data <= (captured mem_to_reg && read) ? dmem_rdata : captured alu_result.
  - reg_wen_out <= captured reg_wen; reg_waddr_out <= captured reg_waddr.
  - Go to IDLE.
- dmem_ack while dmem_req=0 is ignored.
- Reset (asynchronous, any state):
  - state=IDLE, stall=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - wb_data=0, reg_wen_out=0, reg_waddr_out=0.
  - An outstanding request is abandoned and dmem_req drops immediately; the memory must tolerate this.

## Timing
- Non-memory instruction: 1-cycle latency from accept edge to writeback outputs; back-to-back throughput of 1 per cycle.
- Memory instruction:
  - dmem_req rises at the accept edge.
  - Writeback outputs update at the first edge where dmem_ack=1.
  - Minimum latency is 2 cycles (ack in first BUSY cycle).
- stall is high for every BUSY cycle, including the ack cycle.
- The instruction held upstream is accepted on the first IDLE edge after ack, so there is no extra bubble after a completed access.
- Consecutive memory ops: dmem_req falls for exactly 1 cycle between them.

## Test plan
- ALU stream:
  - Stimulus: alu_result=0x1234/0x5678 on consecutive cycles, reg_wen=1, reg_waddr=3/4.
  - Required: wb_data 0x1234 then 0x5678 one cycle later each; stall never asserts.
- Load with 3-cycle memory wait:
  - Stimulus: mem_ren=1, mem_to_reg=1, alu_result=0x0040, reg_waddr=7; ack on 3rd BUSY cycle with dmem_rdata=0xBEEF.
  - Required: dmem_addr=0x0040 and dmem_we=0 stable throughout; stall high 3 cycles; reg_wen_out=0 until wb_data=0xBEEF, reg_wen_out=1, reg_waddr_out=7.
- Store, immediate ack:
  - Stimulus: mem_wen=1, alu_result=0x0010, rdata2=0xA5A5, reg_wen=0.
  - Required: dmem_we=1, dmem_wdata=0xA5A5 for 1 cycle; stall high 1 cycle; reg_wen_out stays 0.
- Held instruction:
  - Stimulus: load followed by ALU op (reg_waddr=2, alu_result=0x0003) held by stall.
  - Required: ALU result appears exactly one cycle after the load's writeback, not lost or duplicated.
- Reset mid-access:
  - Stimulus: assert rst during BUSY, between clock edges.
  - Required: dmem_req, stall and reg_wen_out go to 0 without waiting for an edge; after release, an ALU op completes normally.
- Spurious ack and both-enable:
  - Stimulus: dmem_ack=1 while IDLE, then an instruction with mem_wen=mem_ren=1.
  - Required: no state change from the spurious ack; the second access is issued with dmem_we=1.
